// File: rtl/mod_det3_pkg.sv
// Shared constants, state encoding and helpers for the 3x3 determinant blocks.
// No logic of its own; imported by every determinant module.
// Widths are chosen so that no intermediate cofactor or accumulator value wraps.
package mod_det3_pkg;

    // Datapath widths: 8-bit elements, 17-bit cofactor term, 27-bit accumulator.
    localparam int ELEM_W = 8;
    localparam int T_W    = 17;
    localparam int ACC_W  = 27;
    localparam int PROD_W = ELEM_W + T_W;

    // Matrix has 9 elements; the calculation takes 9 multiply steps.
    localparam int NUM_ELEM = 9;
    localparam int NUM_STEP = 9;
    localparam int CNT_W    = 4;

    localparam logic [CNT_W-1:0] ELEM_FULL = CNT_W'(NUM_ELEM);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(NUM_STEP - 1);

    // Row-major slot indices a..i.
    localparam int SLOT_A = 0;
    localparam int SLOT_B = 1;
    localparam int SLOT_C = 2;
    localparam int SLOT_D = 3;
    localparam int SLOT_E = 4;
    localparam int SLOT_F = 5;
    localparam int SLOT_G = 6;
    localparam int SLOT_H = 7;
    localparam int SLOT_I = 8;

    // Representable range of the 8-bit result.
    localparam logic signed [ACC_W-1:0] RES_MIN = -27'sd128;
    localparam logic signed [ACC_W-1:0] RES_MAX = 27'sd127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } det_state_t;

    // Sign-extend an element to the multiplier's wide operand.
    function automatic logic signed [T_W-1:0] sext_elem(input logic signed [ELEM_W-1:0] v);
        return {{(T_W - ELEM_W){v[ELEM_W-1]}}, v};
    endfunction

    // True when the exact determinant does not fit in a signed byte.
    function automatic logic res_ovf(input logic signed [ACC_W-1:0] v);
        return (v < RES_MIN) || (v > RES_MAX);
    endfunction

endpackage

// File: rtl/mod_mult_s8x17.sv
// Signed 8x17 multiplier shared by all calculation steps.
// Latency: purely combinational.
// Backpressure: none; the controller decides when the product is used.
module mod_mult_s8x17
    import mod_det3_pkg::*;
(
    input  logic signed [ELEM_W-1:0] op_a,
    input  logic signed [T_W-1:0]    op_b,
    output logic signed [PROD_W-1:0] prod
);

    // Both operands are signed, so the product is sign-extended to full width.
    assign prod = op_a * op_b;

endmodule

// File: rtl/mod_det3_ctrl.sv
// 3x3 signed determinant: loads 9 elements, runs 9 multiply steps on one multiplier.
// Latency: out_valid rises 10 edges after the edge that accepts element i.
// Backpressure: in_ready only in IDLE/LOAD; result is held in DONE until out_ready.
module mod_det3_ctrl
    import mod_det3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       abort,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] resultado,
    output logic       ovf,
    output logic       busy
);

    det_state_t state;
    det_state_t state_nxt;

    logic [CNT_W-1:0] elem_cnt;
    logic [CNT_W-1:0] step_cnt;

    logic signed [ELEM_W-1:0] elem [NUM_ELEM];
    logic signed [T_W-1:0]    t;
    logic signed [ACC_W-1:0]  acc;

    logic signed [T_W-1:0]    t_nxt;
    logic signed [ACC_W-1:0]  acc_nxt;

    logic signed [ELEM_W-1:0] mul_a;
    logic signed [T_W-1:0]    mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [T_W-1:0]    prod_t;
    logic signed [ACC_W-1:0]  prod_acc;

    logic             accept;
    logic             cancel;
    logic [CNT_W-1:0] slot_idx;

    // LOAD keeps in_ready low once all 9 slots are filled, giving one
    // turnaround cycle before CALC starts.
    assign in_ready = !rst &&
                      ((state == ST_IDLE) ||
                       ((state == ST_LOAD) && (elem_cnt != ELEM_FULL)));
    assign busy     = (state == ST_LOAD) || (state == ST_CALC);
    assign accept   = in_valid && in_ready;
    // Abort only acts while loading or calculating and wins over an accept.
    assign cancel   = abort && busy;
    assign slot_idx = (state == ST_IDLE) ? '0 : elem_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (elem_cnt == ELEM_FULL) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (step_cnt == STEP_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Element and step counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt <= '0;
            step_cnt <= '0;
        end else if (cancel) begin
            elem_cnt <= '0;
            step_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    step_cnt <= '0;
                    if (accept) begin
                        elem_cnt <= CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + CNT_W'(1);
                    end else if (elem_cnt == ELEM_FULL) begin
                        elem_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    elem_cnt <= elem_cnt;
                    step_cnt <= step_cnt;
                end
            endcase
        end
    end

    // Element slots, written in row-major order as elements are accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_ELEM; k++) begin
                elem[k] <= '0;
            end
        end else if (accept && !cancel) begin
            elem[slot_idx] <= $signed(in_data);
        end
    end

    // Operand selection for the shared multiplier, one product per step.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step_cnt)
            4'd0: begin mul_a = elem[SLOT_E]; mul_b = sext_elem(elem[SLOT_I]); end
            4'd1: begin mul_a = elem[SLOT_F]; mul_b = sext_elem(elem[SLOT_H]); end
            4'd2: begin mul_a = elem[SLOT_A]; mul_b = t;                       end
            4'd3: begin mul_a = elem[SLOT_D]; mul_b = sext_elem(elem[SLOT_I]); end
            4'd4: begin mul_a = elem[SLOT_F]; mul_b = sext_elem(elem[SLOT_G]); end
            4'd5: begin mul_a = elem[SLOT_B]; mul_b = t;                       end
            4'd6: begin mul_a = elem[SLOT_D]; mul_b = sext_elem(elem[SLOT_H]); end
            4'd7: begin mul_a = elem[SLOT_E]; mul_b = sext_elem(elem[SLOT_G]); end
            4'd8: begin mul_a = elem[SLOT_C]; mul_b = t;                       end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
    end

    mod_mult_s8x17 u_mult (
        .op_a (mul_a),
        .op_b (mul_b),
        .prod (prod)
    );

    // Element-by-element products always fit in t; cofactor products need the full width.
    assign prod_t   = prod[T_W-1:0];
    assign prod_acc = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Per-step update of the 2x2 minor (t) and the cofactor expansion (acc).
    always_comb begin
        t_nxt   = t;
        acc_nxt = acc;
        case (step_cnt)
            4'd0, 4'd3, 4'd6: t_nxt   = prod_t;
            4'd1, 4'd4, 4'd7: t_nxt   = t - prod_t;
            4'd2:             acc_nxt = prod_acc;
            4'd5:             acc_nxt = acc - prod_acc;
            4'd8:             acc_nxt = acc + prod_acc;
            default: begin
                t_nxt   = t;
                acc_nxt = acc;
            end
        endcase
    end

    // Working registers, advanced only while calculating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t   <= '0;
            acc <= '0;
        end else if (cancel) begin
            t   <= '0;
            acc <= '0;
        end else if (state == ST_CALC) begin
            t   <= t_nxt;
            acc <= acc_nxt;
        end
    end

    // Result capture on the final step; held through DONE and after, until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultado <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if ((state == ST_CALC) && !abort && (step_cnt == STEP_LAST)) begin
            resultado <= acc_nxt[7:0];
            ovf       <= res_ovf(acc_nxt);
            out_valid <= 1'b1;
        end else if ((state == ST_DONE) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_det3_ctrl.sv
// Directed bench for mod_det3_ctrl with hand-computed determinants.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every comparison goes through chk.
module tb_mod_det3_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] resultado;
    logic       ovf;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    mod_det3_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one element and hold it until it is accepted.
    task automatic push(input logic [7:0] v);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) chk("push_timeout", 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic load_matrix(input logic [71:0] m);
        for (int k = 0; k < 9; k++) begin
            push(m[71 - 8*k -: 8]);
        end
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    // Load a matrix, check latency and result, hold the consumer off for 'hold' cycles.
    task automatic run_matrix(input string tag, input logic [71:0] m,
                              input logic [7:0] exp_res, input logic exp_ovf, input int hold);
        int edges;
        load_matrix(m);
        chk({tag, "_rdy_after_i"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy_after_i"}, {31'd0, busy}, 32'd1);
        wait_result(edges);
        chk({tag, "_latency"}, edges, 32'd10);
        chk({tag, "_res"}, {24'd0, resultado}, {24'd0, exp_res});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_res"}, {24'd0, resultado}, {24'd0, exp_res});
            chk({tag, "_hold_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
            chk({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_again"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_res_kept"}, {24'd0, resultado}, {24'd0, exp_res});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        abort     = 1'b0;
        out_ready = 1'b0;

        // Reset values.
        #2;
        chk("rst_vld",  {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res",  {24'd0, resultado}, 32'd0);
        chk("rst_ovf",  {31'd0, ovf}, 32'd0);
        chk("rst_rdy",  {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rdy", {31'd0, in_ready}, 32'd1);
        tick();

        // in_data wiggling with in_valid low must do nothing.
        in_data = 8'h7F; tick();
        in_data = 8'h80; tick();
        chk("idle_data_busy", {31'd0, busy}, 32'd0);
        chk("idle_data_vld",  {31'd0, out_valid}, 32'd0);
        chk("idle_data_rdy",  {31'd0, in_ready}, 32'd1);

        run_matrix("ones",  72'h01_01_01_01_01_01_01_01_01, 8'h00, 1'b0, 0);
        run_matrix("neg1",  72'h01_01_01_02_01_02_01_01_02, 8'hFF, 1'b0, 0);
        run_matrix("neg",   72'hFF_FC_F9_FE_FD_F8_FF_FE_F9, 8'h0C, 1'b0, 0);
        run_matrix("diag",  72'h64_00_00_00_64_00_00_00_64, 8'h40, 1'b1, 5);
        run_matrix("p127",  72'h7F_00_00_00_01_00_00_00_01, 8'h7F, 1'b0, 0);
        run_matrix("m128",  72'h80_00_00_00_01_00_00_00_01, 8'h80, 1'b0, 1);
        run_matrix("p200",  72'h0A_00_00_00_14_00_00_00_01, 8'hC8, 1'b1, 0);
        run_matrix("big",   72'h80_00_00_00_80_00_00_00_80, 8'h00, 1'b1, 0);
        run_matrix("p200b", 72'h0A_00_00_00_14_00_00_00_01, 8'hC8, 1'b1, 0);

        // Abort in CALC: back to IDLE, previous result untouched, no out_valid.
        load_matrix(72'h01_01_01_02_01_02_01_01_02);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abc_busy", {31'd0, busy}, 32'd0);
        chk("abc_rdy",  {31'd0, in_ready}, 32'd1);
        chk("abc_res",  {24'd0, resultado}, 32'hC8);
        chk("abc_ovf",  {31'd0, ovf}, 32'd1);
        repeat (12) tick();
        chk("abc_novld", {31'd0, out_valid}, 32'd0);

        // Abort in LOAD after 5 elements, with a simultaneous offer that must be dropped.
        for (int k = 0; k < 5; k++) push(8'h33);
        in_valid = 1'b1;
        in_data  = 8'h44;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abl_busy", {31'd0, busy}, 32'd0);
        chk("abl_rdy",  {31'd0, in_ready}, 32'd1);
        chk("abl_res",  {24'd0, resultado}, 32'hC8);
        chk("abl_ovf",  {31'd0, ovf}, 32'd1);
        run_matrix("after_abort", 72'h00_01_02_03_01_02_03_00_00, 8'h00, 1'b0, 0);

        // Reset during CALC step 4.
        run_matrix("pre_rst", 72'hFF_FC_F9_FE_FD_F8_FF_FE_F9, 8'h0C, 1'b0, 0);
        load_matrix(72'h01_01_01_01_01_01_01_01_01);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_res",  {24'd0, resultado}, 32'd0);
        chk("mrst_ovf",  {31'd0, ovf}, 32'd0);
        chk("mrst_vld",  {31'd0, out_valid}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        run_matrix("post_rst", 72'h01_01_01_02_01_02_01_01_02, 8'hFF, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
